// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the pushbutton/slide-switch conditioner.
// Holds the debounce state encoding and the default debounce length.
package button_conditioner_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } dbState_e;

   // 10 ms of stable input at a 100 MHz clock
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/button_conditioner_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Both stages clear to 0 on reset so the first sampled value is a known low.
module sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a pushbutton into a level plus press/release pulses, synchronizes a
// slide switch, and counts the presses accepted while the switch is on.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = 20
) (
   input  logic       clk100,
   input  logic       rst_n,
   input  logic       button,
   input  logic       comSwitch,
   output logic       btn_level,
   output logic       btn_press,
   output logic       btn_release,
   output logic       sw_level,
   output logic       enable,
   output logic [7:0] press_count
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   logic             btnSync;
   dbState_e         state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             btnLevel_q;
   logic             btnPress_q;
   logic             btnRelease_q;
   logic [7:0]       pressCount_q;

   sync2 uBtnSync (
      .clk_i  (clk100),
      .rst_ni (rst_n),
      .d_i    (button),
      .q_o    (btnSync)
   );

   sync2 uSwSync (
      .clk_i  (clk100),
      .rst_ni (rst_n),
      .d_i    (comSwitch),
      .q_o    (sw_level)
   );

   // cnt holds how many consecutive differing samples have been seen, so the
   // entry into a WAIT state already counts as the first one.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RELEASED;
         cnt_q        <= '0;
         btnLevel_q   <= 1'b0;
         btnPress_q   <= 1'b0;
         btnRelease_q <= 1'b0;
      end else begin
         btnPress_q   <= 1'b0;
         btnRelease_q <= 1'b0;
         case (state_q)
            RELEASED: begin
               if (btnSync) begin
                  state_q <= PRESS_WAIT;
                  cnt_q   <= CntOne;
               end else begin
                  cnt_q   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!btnSync) begin
                  state_q <= RELEASED;
                  cnt_q   <= '0;
               end else if (cnt_q == CntLast) begin
                  state_q    <= PRESSED;
                  cnt_q      <= '0;
                  btnLevel_q <= 1'b1;
                  btnPress_q <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + CntOne;
               end
            end
            PRESSED: begin
               if (!btnSync) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= CntOne;
               end else begin
                  cnt_q   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (btnSync) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CntLast) begin
                  state_q      <= RELEASED;
                  cnt_q        <= '0;
                  btnLevel_q   <= 1'b0;
                  btnRelease_q <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + CntOne;
               end
            end
            default: begin
               state_q <= RELEASED;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // The count advances on the edge that closes a press-pulse cycle with the switch on.
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         pressCount_q <= 8'd0;
      end else if (btnPress_q && sw_level) begin
         pressCount_q <= pressCount_q + 8'd1;
      end
   end

   assign btn_level   = btnLevel_q;
   assign btn_press   = btnPress_q;
   assign btn_release = btnRelease_q;
   assign enable      = btnLevel_q & sw_level;
   assign press_count = pressCount_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a run-length debounce model,
// directed scenarios with literal expectations, and a randomized soak.
module tb_button_conditioner;

   localparam int DC = 4;

   logic       clk100    = 1'b0;
   logic       rst_n     = 1'b1;
   logic       button    = 1'b0;
   logic       comSwitch = 1'b0;
   logic       btn_level;
   logic       btn_press;
   logic       btn_release;
   logic       sw_level;
   logic       enable;
   logic [7:0] press_count;

   int testsRun    = 0;
   int testsFailed = 0;
   int pressSeen   = 0;
   int releaseSeen = 0;
   bit checkOn     = 1'b0;

   button_conditioner #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (20)
   ) dut (
      .clk100      (clk100),
      .rst_n       (rst_n),
      .button      (button),
      .comSwitch   (comSwitch),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .sw_level    (sw_level),
      .enable      (enable),
      .press_count (press_count)
   );

   always #5 clk100 = ~clk100;

   // Reference: the accepted level flips once DC consecutive synchronized
   // samples disagree with it; any agreeing sample restarts the run.
   logic [1:0] bPipe    = 2'b00;
   logic [1:0] sPipe    = 2'b00;
   bit         mLevel   = 1'b0;
   bit         mPress   = 1'b0;
   bit         mRelease = 1'b0;
   int         runLen   = 0;
   logic [7:0] mCount   = 8'd0;
   logic       bs;

   always @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         bPipe    = 2'b00;
         sPipe    = 2'b00;
         mLevel   = 1'b0;
         mPress   = 1'b0;
         mRelease = 1'b0;
         runLen   = 0;
         mCount   = 8'd0;
      end else begin
         bs = bPipe[1];
         if (mPress && sPipe[1]) mCount = mCount + 8'd1;
         mPress   = 1'b0;
         mRelease = 1'b0;
         if (bs != mLevel) begin
            runLen = runLen + 1;
            if (runLen == DC) begin
               mLevel   = bs;
               mPress   = bs;
               mRelease = !bs;
               runLen   = 0;
            end
         end else begin
            runLen = 0;
         end
         bPipe = {bPipe[0], button};
         sPipe = {sPipe[0], comSwitch};
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun = testsRun + 1;
      if (actual != expected) begin
         testsFailed = testsFailed + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison against the model, plus pulse bookkeeping.
   always @(negedge clk100) begin
      if (checkOn) begin
         checkOutput("btn_level",   int'(btn_level),   int'(mLevel));
         checkOutput("btn_press",   int'(btn_press),   int'(mPress));
         checkOutput("btn_release", int'(btn_release), int'(mRelease));
         checkOutput("sw_level",    int'(sw_level),    int'(sPipe[1]));
         checkOutput("enable",      int'(enable),      int'(mLevel & sPipe[1]));
         checkOutput("press_count", int'(press_count), int'(mCount));
         checkOutput("pressAndRelease", int'(btn_press & btn_release), 0);
      end
      pressSeen   = pressSeen + int'(btn_press);
      releaseSeen = releaseSeen + int'(btn_release);
   end

   task automatic applyStimulus(input bit b, input bit s, input int cycles);
      @(posedge clk100);
      #2;
      button    = b;
      comSwitch = s;
      repeat (cycles - 1) @(posedge clk100);
   endtask

   task automatic settle();
      @(negedge clk100);
      #1;
   endtask

   task automatic doReset();
      @(posedge clk100);
      #2;
      rst_n     = 1'b0;
      button    = 1'b0;
      comSwitch = 1'b0;
      repeat (2) @(posedge clk100);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #50_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int p0;
      int r0;
      int n;
      bit found;

      #1 rst_n = 1'b0;
      #20;
      checkOutput("resetLevel", int'(btn_level), 0);
      checkOutput("resetCount", int'(press_count), 0);
      doReset();
      checkOn = 1'b1;

      // Press latency: first sampled high at edge 0, pulse visible after edge 5 only.
      @(posedge clk100);
      #2 button = 1'b1;
      repeat (5) @(posedge clk100);
      settle();
      checkOutput("latencyEarlyPress", int'(btn_press), 0);
      @(posedge clk100);
      settle();
      checkOutput("latencyPress", int'(btn_press), 1);
      checkOutput("latencyLevel", int'(btn_level), 1);
      @(posedge clk100);
      settle();
      checkOutput("latencyPressGone", int'(btn_press), 0);
      checkOutput("latencyLevelHeld", int'(btn_level), 1);

      // Three-cycle glitch is rejected.
      doReset();
      p0 = pressSeen;
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b0, 1'b1, 10);
      settle();
      checkOutput("glitchLevel", int'(btn_level), 0);
      checkOutput("glitchPresses", pressSeen - p0, 0);
      checkOutput("glitchCount", int'(press_count), 0);

      // Short release dip keeps the level; a full release gives one pulse.
      doReset();
      applyStimulus(1'b1, 1'b0, 8);
      applyStimulus(1'b0, 1'b0, 2);
      r0 = releaseSeen;
      applyStimulus(1'b1, 1'b0, 8);
      settle();
      checkOutput("dipLevel", int'(btn_level), 1);
      checkOutput("dipReleases", releaseSeen - r0, 0);
      applyStimulus(1'b0, 1'b0, 8);
      settle();
      checkOutput("fullReleases", releaseSeen - r0, 1);
      checkOutput("fullReleaseLevel", int'(btn_level), 0);

      // 256 counted presses wrap the counter; switch off freezes it.
      doReset();
      applyStimulus(1'b0, 1'b1, 4);
      p0 = pressSeen;
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 1'b1, 7);
         if (i == 0) begin
            settle();
            checkOutput("enableOn", int'(enable), 1);
         end
         applyStimulus(1'b0, 1'b1, 7);
         if (i == 254) begin
            settle();
            checkOutput("count255", int'(press_count), 255);
         end
      end
      settle();
      checkOutput("countWrap", int'(press_count), 0);
      checkOutput("wrapPresses", pressSeen - p0, 256);
      applyStimulus(1'b0, 1'b0, 4);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 7);
         if (i == 0) begin
            settle();
            checkOutput("enableSwOff", int'(enable), 0);
            checkOutput("levelSwOff", int'(btn_level), 1);
         end
         applyStimulus(1'b0, 1'b0, 7);
      end
      settle();
      checkOutput("countFrozen", int'(press_count), 0);

      // Reset during PRESS_WAIT clears everything and restarts the debounce.
      doReset();
      applyStimulus(1'b0, 1'b1, 4);
      applyStimulus(1'b1, 1'b1, 7);
      applyStimulus(1'b0, 1'b1, 7);
      settle();
      checkOutput("preResetCount", int'(press_count), 1);
      applyStimulus(1'b1, 1'b1, 4);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rstLevel", int'(btn_level), 0);
      checkOutput("rstPress", int'(btn_press), 0);
      checkOutput("rstSw", int'(sw_level), 0);
      checkOutput("rstCount", int'(press_count), 0);
      @(posedge clk100);
      @(posedge clk100);
      #2 rst_n = 1'b1;
      n = 0;
      found = 1'b0;
      while (!found && n < 20) begin
         @(posedge clk100);
         n = n + 1;
         settle();
         if (btn_press) found = 1'b1;
      end
      checkOutput("resetPressLatency", n, 6);

      // Randomized soak with occasional asynchronous resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            @(posedge clk100);
            #($urandom_range(1, 4)) rst_n = 1'b0;
            @(posedge clk100);
            #2 rst_n = 1'b1;
         end
         @(posedge clk100);
         #2;
         button = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) comSwitch = ~comSwitch;
         repeat ($urandom_range(0, 6)) @(posedge clk100);
      end
      applyStimulus(1'b0, comSwitch, 10);
      settle();

      checkOn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
